fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter: NREQ, default 4, number of write requesters; legal 2..8.
REQ-002 Parameter: DATA_WD, default 8, FIFO word width; it SHALL equal the width of the FIFO write data port.
REQ-003 Parameter: MAX_BURST, default 4, maximum number of words per grant; legal 1..15.
REQ-004 Port: wclk, input, 1, write-domain clock; all state SHALL update on its rising edge.
REQ-005 Port: wrst_n, input, 1, asynchronous active-low reset.
REQ-006 Port: req, input, NREQ, per-requester "word valid"; bit i high means requester i presents a word.
REQ-007 Port: req_data, input, NREQ*DATA_WD, packed words; requester i occupies bits [i*DATA_WD +: DATA_WD].
REQ-008 Port: wfull, input, 1, FIFO full flag in the wclk domain.
REQ-009 Port: grant, output, NREQ, one-hot current owner; all zero when no owner.
REQ-010 Port: ack, output, NREQ, one-hot; bit i high means requester i's word is written this cycle.
REQ-011 Port: winc, output, 1, FIFO write enable.
REQ-012 Port: wdata, output, DATA_WD, FIFO write data.

Function
REQ-013 State machine: two states, IDLE and BUSY; state, owner index, last-owner index and burst counter SHALL be registers.
REQ-014 IDLE: if req is nonzero, the block SHALL select the first set bit searching upward (modulo NREQ) from last_owner+1, register it as owner and enter BUSY next cycle; otherwise it SHALL stay in IDLE.
REQ-015 IDLE: grant, ack and winc SHALL be 0; no write occurs in the arbitration cycle.
REQ-016 BUSY: grant SHALL be one-hot at owner.
REQ-017 BUSY write condition: winc = req[owner] AND NOT wfull, combinational in the same cycle.
REQ-018 BUSY ack: ack SHALL equal winc shifted to bit owner.
REQ-019 BUSY wdata: wdata SHALL equal the owner's req_data slice at all times.
REQ-020 IDLE wdata: wdata SHALL be 0 in IDLE.
REQ-021 Burst counter: width clog2(MAX_BURST+1); it SHALL clear on entry to BUSY and increment by 1 on each winc.
REQ-022 Release: BUSY SHALL return to IDLE next cycle when (a) req[owner] is low (no write that cycle), or (b) winc is high and the counter equals MAX_BURST-1.
REQ-023 On release, last_owner SHALL be loaded with owner.
REQ-024 wfull high with req[owner] high SHALL stall: no write, no counter change, no release, for any number of cycles.
REQ-025 Requests from non-owners during BUSY SHALL be ignored until the next IDLE cycle.
REQ-026 Requesters SHALL hold req and data stable until acked; the block SHALL NOT write a word without a matching ack.
REQ-027 Fairness: a continuously requesting requester SHALL be granted within NREQ-1 grants of other requesters.
REQ-028 Invariants: winc SHALL never be high while wfull is high; ack SHALL always be zero or one-hot.

Reset
REQ-029 wrst_n low SHALL asynchronously force state=IDLE, owner=0, last_owner=NREQ-1, counter=0, grant=0, ack=0, winc=0, wdata=0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no further write; after release, requester 0 SHALL have first priority.
REQ-031 Reset release SHALL be synchronous to wclk externally; the first arbitration SHALL occur on the first rising edge with wrst_n high.

Verification
REQ-032 Single requester: req=0001, wfull=0, data 0x11..0x16 -> grant 0001; acks on words 0x11..0x14 on 4 consecutive cycles; 1 IDLE cycle; then 0x15, 0x16.
REQ-033 Round robin: req=1111 held, wfull=0 -> grant order 0,1,2,3,0; 4 words each; each grant is followed by exactly one IDLE cycle.
REQ-034 Full stall: owner 2 with wfull high for 5 cycles after its 2nd word -> winc=0 and counter=2 throughout; burst completes with words 3 and 4 after wfull drops.
REQ-035 Early release: owner 1 drops req after 2 acks -> IDLE next cycle; last_owner=1; a pending req3 is granted before req0.
REQ-036 Reset mid-burst: wrst_n low after owner 3's 1st ack -> outputs 0 immediately; after release with req=1001, requester 0 is granted first.
REQ-037 Integration: connect to the async FIFO with wclk 100 MHz and rclk 37 MHz, NREQ=4 random traffic, 10k words -> per-requester read order is preserved; no loss or duplication; winc&wfull is never observed.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter for an async-FIFO write port: grants one requester at a
// time for a burst of up to MAX_BURST words, stalls on wfull, releases on idle/burst end.
module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int DATA_WD   = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATA_WD-1:0]   req_data,
  input  logic                      wfull,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           ack,
  output logic                      winc,
  output logic [DATA_WD-1:0]        wdata
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic               own_req;

  // Walk downward so the candidate closest to last_owner+1 is the one left standing.
  always_comb begin
    pick = last_owner_q;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_owner_q) + k) % NREQ);
      if (req[cand]) pick = cand;
    end
  end

  assign own_req = req[owner_q];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    grant        = '0;
    ack          = '0;
    winc         = 1'b0;
    wdata        = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        grant = NREQ'(1) << owner_q;
        winc  = own_req & ~wfull;
        ack   = winc ? grant : '0;
        wdata = req_data[int'(owner_q)*DATA_WD +: DATA_WD];
        if (winc) cnt_d = cnt_q + 1'b1;
        // A stalled owner (req high, wfull high) neither writes nor releases.
        if (!own_req || (winc && (cnt_q == CNT_LAST))) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios with hand-derived waveforms, then random
// traffic checked against rule-level arbitration, burst and per-requester order models.
module tb_fifo_wr_arb;
  localparam int NREQ = 4, DATA_WD = 8, MAX_BURST = 4;

  logic                    wclk = 1'b0;
  logic                    wrst_n;
  logic [NREQ-1:0]         req;
  logic [NREQ*DATA_WD-1:0] req_data;
  logic                    wfull;
  logic [NREQ-1:0]         grant, ack;
  logic                    winc;
  logic [DATA_WD-1:0]      wdata;

  fifo_wr_arb #(.NREQ(NREQ), .DATA_WD(DATA_WD), .MAX_BURST(MAX_BURST)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .wfull(wfull),
    .grant(grant), .ack(ack), .winc(winc), .wdata(wdata)
  );

  always #5 wclk = ~wclk;

  int tests = 0, fails = 0;
  logic [7:0]      q[NREQ][$];
  int              gap[NREQ];
  int              sent[NREQ];
  int              waitcnt[NREQ];
  bit              rnd_mode;
  logic [NREQ-1:0] prev_req, prev_grant;
  int              model_last, burst_words;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    model_last  = NREQ - 1;
    prev_grant  = '0;
    burst_words = 0;
    for (int i = 0; i < NREQ; i++) waitcnt[i] = 0;
  endtask

  task automatic run_cycle(input logic wf);
    int own, np;
    logic [NREQ-1:0] eg;
    logic [7:0] ed;
    @(negedge wclk);
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (q[i].size() > 0) && (gap[i] == 0);
      if (req[i]) req_data[i*DATA_WD +: DATA_WD] = q[i][0];
      else req_data[i*DATA_WD +: DATA_WD] = rnd_mode ? 8'($urandom) : 8'h00;
      if (gap[i] > 0) gap[i]--;
    end
    wfull = wf;
    #1;
    if (!wrst_n) begin
      chk("rst.grant", grant, 0);
      chk("rst.ack", ack, 0);
      chk("rst.winc", winc, 0);
      chk("rst.wdata", wdata, 0);
      model_reset();
    end else begin
      own = idx_of(grant);
      chk("grant_onehot0", $countones(grant) <= 1, 1);
      chk("winc_rule", winc, (grant != 0) && ((req & grant) != 0) && !wfull);
      chk("ack_rule", ack, winc ? grant : '0);
      if (own < 0) ed = 8'h00;
      else ed = req_data[own*DATA_WD +: DATA_WD];
      chk("wdata_rule", wdata, ed);
      if (prev_grant == 0) begin
        np = rr_pick(prev_req, model_last);
        eg = (np < 0) ? '0 : NREQ'(1) << np;
        chk("arb_pick", grant, eg);
        burst_words = 0;
        if (grant != 0) begin
          for (int i = 0; i < NREQ; i++) begin
            if (i == own) waitcnt[i] = 0;
            else if (prev_req[i]) begin
              waitcnt[i]++;
              chk("fairness", waitcnt[i] <= NREQ - 1, 1);
            end else waitcnt[i] = 0;
          end
        end
      end else begin
        if ((prev_req & prev_grant) == 0) eg = '0;
        else if (burst_words == MAX_BURST) eg = '0;
        else eg = prev_grant;
        chk("hold_release", grant, eg);
        if (grant == 0) begin
          model_last  = idx_of(prev_grant);
          burst_words = 0;
        end
      end
      if (ack != 0 && own >= 0) begin
        burst_words++;
        chk("sb_order", wdata, q[own][0]);
        void'(q[own].pop_front());
        sent[own]++;
        gap[own] = rnd_mode ? $urandom_range(0, 3) : 0;
      end
    end
    prev_req   = req;
    prev_grant = grant;
  endtask

  task automatic step(input string tag, input logic wf, input logic [NREQ-1:0] eg,
                      input logic [NREQ-1:0] ea, input logic [7:0] ew);
    run_cycle(wf);
    chk({tag, ".grant"}, grant, eg);
    chk({tag, ".ack"}, ack, ea);
    chk({tag, ".winc"}, winc, |ea);
    chk({tag, ".wdata"}, wdata, ew);
  endtask

  task automatic enter_reset();
    wrst_n = 1'b0;
    run_cycle(1'b0);
    for (int i = 0; i < NREQ; i++) begin
      q[i].delete();
      gap[i]  = 0;
      sent[i] = 0;
    end
  endtask

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    logic [7:0] base;
    bit done;
    rnd_mode = 1'b0;
    wrst_n = 1'b0; wfull = 1'b0; req = '0; req_data = '0;
    prev_req = '0;
    for (int i = 0; i < NREQ; i++) begin gap[i] = 0; sent[i] = 0; end
    model_reset();

    // Reset state
    run_cycle(1'b0);
    chk("rst.last_owner", dut.last_owner_q, NREQ - 1);
    chk("rst.cnt", dut.cnt_q, 0);
    chk("rst.owner", dut.owner_q, 0);

    // Single requester, 6 words: burst of 4, one idle cycle, then 2
    for (int k = 0; k < 6; k++) q[0].push_back(8'h11 + 8'(k));
    run_cycle(1'b0);
    wrst_n = 1'b1;
    step("A1", 0, 4'b0001, 4'b0001, 8'h11);
    step("A2", 0, 4'b0001, 4'b0001, 8'h12);
    step("A3", 0, 4'b0001, 4'b0001, 8'h13);
    step("A4", 0, 4'b0001, 4'b0001, 8'h14);
    step("A5", 0, 4'b0000, 4'b0000, 8'h00);
    step("A6", 0, 4'b0001, 4'b0001, 8'h15);
    step("A7", 0, 4'b0001, 4'b0001, 8'h16);
    step("A8", 0, 4'b0001, 4'b0000, 8'h00);
    step("A9", 0, 4'b0000, 4'b0000, 8'h00);

    // Round robin with all four requesting
    enter_reset();
    for (int k = 0; k < 8; k++) q[0].push_back(8'h10 + 8'(k));
    for (int i = 1; i < NREQ; i++)
      for (int k = 0; k < 4; k++) q[i].push_back(8'((i + 1) * 16 + k));
    run_cycle(1'b0);
    wrst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      base = 8'((order[n] + 1) * 16 + ((n == 4) ? 4 : 0));
      for (int w = 0; w < MAX_BURST; w++)
        step("B", 0, NREQ'(1) << order[n], NREQ'(1) << order[n], base + 8'(w));
      step("B_idle", 0, 4'b0000, 4'b0000, 8'h00);
    end

    // Full stall after the owner's second word
    enter_reset();
    for (int k = 0; k < 4; k++) q[2].push_back(8'h31 + 8'(k));
    run_cycle(1'b0);
    wrst_n = 1'b1;
    step("C1", 0, 4'b0100, 4'b0100, 8'h31);
    step("C2", 0, 4'b0100, 4'b0100, 8'h32);
    for (int s = 0; s < 5; s++) begin
      step("C_stall", 1, 4'b0100, 4'b0000, 8'h33);
      chk("C_stall.cnt", dut.cnt_q, 2);
    end
    step("C3", 0, 4'b0100, 4'b0100, 8'h33);
    step("C4", 0, 4'b0100, 4'b0100, 8'h34);
    step("C5", 0, 4'b0000, 4'b0000, 8'h00);

    // Early release; pending req3 wins over req0
    enter_reset();
    q[1].push_back(8'h51); q[1].push_back(8'h52);
    run_cycle(1'b0);
    wrst_n = 1'b1;
    step("D1", 0, 4'b0010, 4'b0010, 8'h51);
    q[0].push_back(8'h61); q[3].push_back(8'h81);
    step("D2", 0, 4'b0010, 4'b0010, 8'h52);
    step("D3", 0, 4'b0010, 4'b0000, 8'h00);
    step("D4", 0, 4'b0000, 4'b0000, 8'h00);
    chk("D4.last_owner", dut.last_owner_q, 1);
    step("D5", 0, 4'b1000, 4'b1000, 8'h81);
    step("D6", 0, 4'b1000, 4'b0000, 8'h00);
    step("D7", 0, 4'b0000, 4'b0000, 8'h00);
    step("D8", 0, 4'b0001, 4'b0001, 8'h61);
    step("D9", 0, 4'b0001, 4'b0000, 8'h00);
    step("D10", 0, 4'b0000, 4'b0000, 8'h00);

    // Reset mid-burst after the first word of owner 3
    enter_reset();
    for (int k = 0; k < 3; k++) q[3].push_back(8'h91 + 8'(k));
    run_cycle(1'b0);
    wrst_n = 1'b1;
    step("E1", 0, 4'b1000, 4'b1000, 8'h91);
    @(posedge wclk);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("E_async.grant", grant, 0);
    chk("E_async.ack", ack, 0);
    chk("E_async.winc", winc, 0);
    chk("E_async.wdata", wdata, 0);
    model_reset();
    q[0].push_back(8'hA1);
    run_cycle(1'b0);
    wrst_n = 1'b1;
    step("E2", 0, 4'b0001, 4'b0001, 8'hA1);
    step("E3", 0, 4'b0001, 4'b0000, 8'h00);
    step("E4", 0, 4'b0000, 4'b0000, 8'h00);
    step("E5", 0, 4'b1000, 4'b1000, 8'h92);
    step("E6", 0, 4'b1000, 4'b1000, 8'h93);
    step("E7", 0, 4'b1000, 4'b0000, 8'h00);
    step("E8", 0, 4'b0000, 4'b0000, 8'h00);

    // Random traffic with request gaps and wfull back-pressure
    enter_reset();
    rnd_mode = 1'b1;
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 30; k++) q[i].push_back(8'($urandom));
    run_cycle(1'b0);
    wrst_n = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      run_cycle($urandom_range(0, 3) == 0);
      done = 1'b1;
      for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) done = 1'b0;
    end
    chk("R.drained", done, 1);
    for (int i = 0; i < NREQ; i++) chk("R.sent", sent[i], 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
